// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: writeback result-select encodings shared by the MEM/WB stage.
package mem_wb_stage_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
endpackage

// File: rtl/mem_wb_stage_wb_pipe_reg.sv
// wb_pipe_reg: W-stage pipeline register with async reset, enable and sync clear (clear beats enable).
module wb_pipe_reg #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB register with result select, regfile write qualification and retire counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ValidM,
  input  logic [XLEN-1:0]   muxpal_result,
  input  logic [XLEN-1:0]   ReadData,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [REG_AW-1:0] RdM,
  input  logic              RegWriteM,
  input  logic              FRegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic              StallW,
  input  logic              FlushW,
  output logic [XLEN-1:0]   ResultW,
  output logic [REG_AW-1:0] RdW,
  output logic              RegWriteW,
  output logic              FRegWriteW,
  output logic              ValidW,
  output logic [CNT_W-1:0]  InstRet,
  output logic              ConflictErr
);
  logic [XLEN-1:0] result_m;
  logic regw_m, fregw_m, regw_q, fregw_q, load, conflict;
  assign result_m = ResultSrcM == RES_MEM ? ReadData :
                    ResultSrcM == RES_PC4 ? PCPlus4M : muxpal_result;
  assign conflict = ValidM & RegWriteM & FRegWriteM;
  // float write wins a dual-write request
  assign regw_m   = ValidM & RegWriteM & ~FRegWriteM;
  assign fregw_m  = ValidM & FRegWriteM;
  assign load     = ~FlushW & ~StallW;
  wb_pipe_reg #(.W(XLEN + REG_AW + 3)) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (~StallW),
    .clr  (FlushW),
    .d    ({result_m, RdM, ValidM, regw_m, fregw_m}),
    .q    ({ResultW, RdW, ValidW, regw_q, fregw_q})
  );
  assign RegWriteW  = ValidW & regw_q & (RdW != '0);
  assign FRegWriteW = ValidW & fregw_q;
  // a flushed W entry has still completed, so it retires even under stall
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      InstRet     <= '0;
      ConflictErr <= 1'b0;
    end else begin
      if (ValidW && (!StallW || FlushW)) InstRet <= InstRet + CNT_W'(1);
      if (load && conflict) ConflictErr <= 1'b1;
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors with scoreboard queue; a 2-bit-counter twin checks wraparound.
module tb_mem_wb_stage;
  logic clk = 0, rst_n = 0;
  logic valid_m = 0, regw = 0, fregw = 0, stall = 0, flush = 0;
  logic [31:0] alu = 0, rdata = 0, pc4 = 0;
  logic [4:0] rd_m = 0;
  logic [1:0] src = 0;
  logic [31:0] res_w, res_w2, cnt_w;
  logic [4:0] rd_w, rd_w2;
  logic rw_w, frw_w, v_w, cf_w, rw_w2, frw_w2, v_w2, cf_w2;
  logic [1:0] cnt_w2;
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw, frw, v, cf;
    int unsigned cnt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .ValidM(valid_m), .muxpal_result(alu), .ReadData(rdata),
    .PCPlus4M(pc4), .RdM(rd_m), .RegWriteM(regw), .FRegWriteM(fregw), .ResultSrcM(src),
    .StallW(stall), .FlushW(flush), .ResultW(res_w), .RdW(rd_w), .RegWriteW(rw_w),
    .FRegWriteW(frw_w), .ValidW(v_w), .InstRet(cnt_w), .ConflictErr(cf_w)
  );

  mem_wb_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ValidM(valid_m), .muxpal_result(alu), .ReadData(rdata),
    .PCPlus4M(pc4), .RdM(rd_m), .RegWriteM(regw), .FRegWriteM(fregw), .ResultSrcM(src),
    .StallW(stall), .FlushW(flush), .ResultW(res_w2), .RdW(rd_w2), .RegWriteW(rw_w2),
    .FRegWriteW(frw_w2), .ValidW(v_w2), .InstRet(cnt_w2), .ConflictErr(cf_w2)
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] r,
                      input logic [31:0] p, input logic [4:0] d, input logic w, input logic fw,
                      input logic [1:0] s, input logic st, input logic fl,
                      input logic [31:0] e_res, input logic [4:0] e_rd, input logic e_rw,
                      input logic e_frw, input logic e_v, input int unsigned e_cnt,
                      input logic e_cf);
    exp_t e;
    valid_m = v; alu = a; rdata = r; pc4 = p; rd_m = d; regw = w; fregw = fw;
    src = s; stall = st; flush = fl;
    e.res = e_res; e.rd = e_rd; e.rw = e_rw; e.frw = e_frw; e.v = e_v; e.cnt = e_cnt; e.cf = e_cf;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ResultW", res_w, e.res);
      chk("RdW", rd_w, e.rd);
      chk("RegWriteW", rw_w, e.rw);
      chk("FRegWriteW", frw_w, e.frw);
      chk("ValidW", v_w, e.v);
      chk("InstRet", cnt_w, e.cnt);
      chk("ConflictErr", cf_w, e.cf);
      chk("InstRet_wrap2", cnt_w2, e.cnt % 4);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_ResultW", res_w, 0);
    chk("reset_ValidW", v_w, 0);
    chk("reset_InstRet", cnt_w, 0);
    chk("reset_ConflictErr", cf_w, 0);
    @(negedge clk);
    rst_n = 1;
    //   v  alu           rdata         pc4     rd w fw src st fl | res           rd w fw v cnt cf
    step(1, 32'h37800000, 0,            0,      9, 0, 1, 2'b00, 0, 0, 32'h37800000, 9, 0, 1, 1, 0, 0);
    step(1, 32'h11111111, 32'hDEADBEEF, 0,      3, 1, 0, 2'b01, 0, 0, 32'hDEADBEEF, 3, 1, 0, 1, 1, 0);
    step(1, 0,            0,            32'h104,1, 1, 0, 2'b10, 0, 0, 32'h104,      1, 1, 0, 1, 2, 0);
    step(1, 8,            0,            0,      0, 1, 0, 2'b00, 0, 0, 8,            0, 0, 0, 1, 3, 0);
    step(1, 32'h55,       32'hAA,       32'hBB, 5, 1, 0, 2'b11, 0, 0, 32'h55,       5, 1, 0, 1, 4, 0);
    for (int i = 0; i < 3; i++)
      step(1, 32'h99,     0,            0,      7, 1, 0, 2'b00, 1, 0, 32'h55,       5, 1, 0, 1, 4, 0);
    step(1, 32'h77,       0,            0,      6, 1, 0, 2'b00, 1, 1, 0,            0, 0, 0, 0, 5, 0);
    step(0, 32'h42,       0,            0,      4, 1, 1, 2'b00, 0, 0, 32'h42,       4, 0, 0, 0, 5, 0);
    step(1, 32'h10,       0,            0,      2, 1, 0, 2'b00, 0, 0, 32'h10,       2, 1, 0, 1, 5, 0);
    step(1, 32'h20,       0,            0,      3, 1, 0, 2'b00, 0, 1, 0,            0, 0, 0, 0, 6, 0);
    step(1, 32'h3F800000, 0,            0,      8, 1, 1, 2'b00, 0, 0, 32'h3F800000, 8, 0, 1, 1, 6, 1);
    step(1, 1,            0,            0,     10, 1, 0, 2'b00, 0, 0, 1,           10, 1, 0, 1, 7, 1);
    step(0, 0,            0,            0,      0, 0, 0, 2'b00, 0, 0, 0,            0, 0, 0, 0, 8, 1);
    step(1, 5,            0,            0,     11, 1, 0, 2'b00, 0, 0, 5,           11, 1, 0, 1, 8, 1);
    valid_m = 0; regw = 0; fregw = 0; alu = 0; rd_m = 0;
    #2;
    rst_n = 0;
    #1;
    chk("async_ResultW", res_w, 0);
    chk("async_RdW", rd_w, 0);
    chk("async_RegWriteW", rw_w, 0);
    chk("async_ValidW", v_w, 0);
    chk("async_InstRet", cnt_w, 0);
    chk("async_ConflictErr", cf_w, 0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
